// File: rtl/complex_mult_sequencer_if.sv
// Butterfly-side operand/result stream of the complex multiply sequencer.
// The master drives operands and result ready; the slave is the sequencer.
interface complex_mult_sequencer_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] ar;
    logic signed [15:0] ai;
    logic signed [15:0] br;
    logic signed [15:0] bi;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               err;

    modport master (
        output in_valid, ar, ai, br, bi, out_ready,
        input  in_ready, out_valid, out_re, out_im, err
    );

    modport slave (
        input  in_valid, ar, ai, br, bi, out_ready,
        output in_ready, out_valid, out_re, out_im, err
    );
endinterface

// File: rtl/complex_mult_sequencer.sv
// Sequences one shared pipelined Q1.15 multiplier through the four products of a complex multiply.
// Define COMPLEX_CONJ_EN to add conj_b, which multiplies by conj(b) instead of b.
module complex_mult_sequencer #(
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    complex_mult_sequencer_if.slave  bus,
`ifdef COMPLEX_CONJ_EN
    input  logic                     conj_b,
`endif
    output logic                     mul_enable,
    output logic [15:0]              mul_a,
    output logic [15:0]              mul_b,
    input  logic [15:0]              mul_product,
    input  logic                     mul_done
);
    localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMBINE, OUTPUT} state_t;

    state_t             state, next_state;
    logic [1:0]         idx;
    logic [2:0]         done_cnt, done_cnt_next;
    logic [TW-1:0]      timer;
    logic signed [15:0] ar_q, ai_q, br_q, bi_q;
    logic signed [15:0] p [4];
    logic signed [16:0] diff, sum;
    logic               accept, issue, capture, combine, timeout;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)
            return 16'sh7fff;
        else if (v < -17'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

`ifdef COMPLEX_CONJ_EN
    function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
        return (v == 16'sh8000) ? 16'sh7fff : -v;
    endfunction
`endif

    assign diff = $signed({p[0][15], p[0]}) - $signed({p[1][15], p[1]});
    assign sum  = $signed({p[2][15], p[2]}) + $signed({p[3][15], p[3]});

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Control strobes; dones are only meaningful while a transaction is in flight.
    always_comb begin
        accept        = (state == IDLE) && bus.in_valid && bus.in_ready;
        issue         = (state == ISSUE);
        combine       = (state == COMBINE);
        capture       = mul_done && (done_cnt < 3'd4) &&
                        ((state == ISSUE) || (state == WAIT) || (state == COMBINE));
        done_cnt_next = done_cnt + {2'b00, capture};
        timeout       = (state == WAIT) && (done_cnt_next != 3'd4) &&
                        (timer == TW'(DONE_TIMEOUT - 1));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   if (idx == 2'd3) next_state = WAIT;
            WAIT: begin
                if (done_cnt_next == 3'd4)
                    next_state = COMBINE;
                else if (timeout)
                    next_state = OUTPUT;
            end
            COMBINE: next_state = OUTPUT;
            OUTPUT:  if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.err       <= 1'b0;
            mul_enable    <= 1'b0;
            mul_a         <= '0;
            mul_b         <= '0;
            idx           <= '0;
            done_cnt      <= '0;
            timer         <= '0;
            ar_q          <= '0;
            ai_q          <= '0;
            br_q          <= '0;
            bi_q          <= '0;
            for (int unsigned i = 0; i < 4; i++) p[i] <= '0;
        end else begin
            bus.in_ready  <= (next_state == IDLE);
            bus.out_valid <= (next_state == OUTPUT);
            mul_enable    <= issue;
            done_cnt      <= done_cnt_next;

            if (accept) begin
                ar_q     <= bus.ar;
                ai_q     <= bus.ai;
                br_q     <= bus.br;
`ifdef COMPLEX_CONJ_EN
                bi_q     <= conj_b ? neg_sat(bus.bi) : bus.bi;
`else
                bi_q     <= bus.bi;
`endif
                bus.err  <= 1'b0;
                idx      <= '0;
                done_cnt <= '0;
                timer    <= '0;
            end

            if (issue) begin
                case (idx)
                    2'd0:    begin mul_a <= ar_q; mul_b <= br_q; end
                    2'd1:    begin mul_a <= ai_q; mul_b <= bi_q; end
                    2'd2:    begin mul_a <= ar_q; mul_b <= bi_q; end
                    default: begin mul_a <= ai_q; mul_b <= br_q; end
                endcase
                idx <= idx + 2'd1;
            end else begin
                mul_a <= '0;
                mul_b <= '0;
            end

            if (capture)
                p[done_cnt[1:0]] <= mul_product;

            if (state == WAIT)
                timer <= timer + 1'b1;

            if (timeout) begin
                bus.err    <= 1'b1;
                bus.out_re <= '0;
                bus.out_im <= '0;
            end

            if (combine) begin
                bus.out_re <= sat16(diff);
                bus.out_im <= sat16(sum);
            end
        end
    end
endmodule

// File: tb/tb_complex_mult_sequencer.sv
// Directed bench for complex_mult_sequencer with a 2-cycle saturating Q1.15 multiplier model
// that can drop one done pulse or inject a stray one.
module tb_complex_mult_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        mul_enable;
    logic [15:0] mul_a, mul_b, mul_product;
    logic        mul_done;
`ifdef COMPLEX_CONJ_EN
    logic        conj_b;
`endif

    complex_mult_sequencer_if bus ();

    complex_mult_sequencer #(.DONE_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
`ifdef COMPLEX_CONJ_EN
        .conj_b      (conj_b),
`endif
        .mul_enable  (mul_enable),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_done    (mul_done)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    int   drop_at = -1;
    logic stray = 1'b0;
    logic s1_v = 1'b0, done_q = 1'b0;
    logic [15:0] s1_p = '0, prod_q = '0;

    function automatic logic [15:0] qmul(input logic signed [15:0] a, input logic signed [15:0] b);
        int m;
        m = (int'(a) * int'(b)) >>> 15;
        if (m > 32767) m = 32767;
        if (m < -32768) m = -32768;
        return 16'(m);
    endfunction

    always @(posedge clk) begin
        s1_v   <= mul_enable;
        s1_p   <= qmul($signed(mul_a), $signed(mul_b));
        done_q <= s1_v && (pulse_cnt != drop_at);
        prod_q <= s1_p;
        if (s1_v) pulse_cnt <= pulse_cnt + 1;
    end

    assign mul_done    = done_q | stray;
    assign mul_product = prod_q;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents operands from a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic signed [15:0] a_r, input logic signed [15:0] a_i,
                        input logic signed [15:0] b_r, input logic signed [15:0] b_i,
                        input logic cj);
        int n;
        n = 0;
        bus.ar = a_r; bus.ai = a_i; bus.br = b_r; bus.bi = b_i;
`ifdef COMPLEX_CONJ_EN
        conj_b = cj;
`else
        if (cj) $display("conj request ignored in this build");
`endif
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic signed [15:0] a_r, input logic signed [15:0] a_i,
                       input logic signed [15:0] b_r, input logic signed [15:0] b_i, input logic cj,
                       input int exp_re, input int exp_im);
        int lat;
        send(a_r, a_i, b_r, b_i, cj);
        wait_out(lat);
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_re"}, bus.out_re, exp_re);
        chk({tag, "_im"}, bus.out_im, exp_im);
        chk({tag, "_err"}, bus.err, 0);
        @(negedge clk);
        chk({tag, "_consumed"}, bus.out_valid, 0);
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.ar = '0; bus.ai = '0; bus.br = '0; bus.bi = '0;
`ifdef COMPLEX_CONJ_EN
        conj_b = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_re", bus.out_re, 0);
        chk("rst_out_im", bus.out_im, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_mul_enable", mul_enable, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", bus.in_ready, 1);

        run("half", 16384, 16384, 16384, 16384, 1'b0, 0, 16384);
        run("mixed", 16384, 8192, -16384, 4096, 1'b0, -9216, -2048);
        run("minsat", -32768, 0, -32768, 0, 1'b0, 32767, 0);
        run("maxsat", 32767, 32767, 32767, 32767, 1'b0, 0, 32767);

        // Backpressure: result held while out_ready is low.
        bus.out_ready = 1'b0;
        send(16384, 16384, 16384, 16384, 1'b0);
        wait_out(lat);
        chk("stall_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_re", bus.out_re, 0);
            chk("stall_im", bus.out_im, 16384);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_consumed", bus.out_valid, 0);
        chk("stall_in_ready_back", bus.in_ready, 1);

        // Dropped third done: abort after the timeout window.
        drop_at = pulse_cnt + 2;
        send(16384, 16384, 16384, 16384, 1'b0);
        wait_out(lat);
        chk("timeout_latency", lat, 19);
        chk("timeout_err", bus.err, 1);
        chk("timeout_re", bus.out_re, 0);
        chk("timeout_im", bus.out_im, 0);
        @(negedge clk);
        drop_at = -1;
        chk("timeout_consumed", bus.out_valid, 0);
        chk("err_sticky", bus.err, 1);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        send(16384, 16384, 16384, 16384, 1'b0);
        chk("err_cleared_on_accept", bus.err, 0);
        wait_out(lat);
        chk("after_stray_latency", lat, 8);
        chk("after_stray_re", bus.out_re, 0);
        chk("after_stray_im", bus.out_im, 16384);
        @(negedge clk);

        // Reset at T+5 with multiplier results still in flight.
        send(32767, 32767, 32767, 32767, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_mul_enable", mul_enable, 0);
        chk("midrst_mul_a", mul_a, 0);
        chk("midrst_err", bus.err, 0);
        reset = 1'b0;
        run("post_reset", 16384, 16384, 16384, 16384, 1'b0, 0, 16384);

`ifdef COMPLEX_CONJ_EN
        run("conj", 16384, 16384, 16384, 16384, 1'b1, 16384, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
